triangle_edge_scheduler: RTL and testbench

- Queues incoming triangles and sequences each triangle's three edges, one at a time, to the downstream line-rasterizer engine.
- Uses a valid/ready issue handshake and waits for a line_done completion pulse before issuing the next edge.
- Sits between the primitive source and the line engine; it is the sole master of the line engine's endpoint inputs.

---
 rtl/tri_pkg.sv | 26 ++
 rtl/tri_fifo.sv | 54 +++++
 rtl/triangle_edge_scheduler.sv | 170 +++++++++++++++++
 tb/tb_triangle_edge_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle edge scheduler.
package tri_pkg;

  localparam int unsigned COORD_W_DEFAULT = 32;

  // Fixed edge order within a triangle.
  localparam logic [1:0] EDGE_V1V2 = 2'd0;
  localparam logic [1:0] EDGE_V1V3 = 2'd1;
  localparam logic [1:0] EDGE_V2V3 = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x1;
    logic [COORD_W_DEFAULT-1:0] y1;
    logic [COORD_W_DEFAULT-1:0] x2;
    logic [COORD_W_DEFAULT-1:0] y2;
    logic [COORD_W_DEFAULT-1:0] x3;
    logic [COORD_W_DEFAULT-1:0] y3;
  } tri_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO of triangle records; read data is the current head.
module tri_fifo
  import tri_pkg::*;
#(
  parameter type         T     = tri_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (count_q < (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Pointer and occupancy tracking; reset flushes the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/triangle_edge_scheduler.sv
// Queues triangles and issues their three edges one at a time to a line engine.
module triangle_edge_scheduler
  import tri_pkg::*;
#(
  parameter int unsigned COORD_W         = COORD_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter bit          SKIP_DEGENERATE = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tri_valid,
  output logic                          tri_ready,
  input  logic [COORD_W-1:0]            x_vertice_1,
  input  logic [COORD_W-1:0]            x_vertice_2,
  input  logic [COORD_W-1:0]            x_vertice_3,
  input  logic [COORD_W-1:0]            y_vertice_1,
  input  logic [COORD_W-1:0]            y_vertice_2,
  input  logic [COORD_W-1:0]            y_vertice_3,
  output logic                          edge_valid,
  input  logic                          edge_ready,
  output logic [COORD_W-1:0]            x_coordinate_1,
  output logic [COORD_W-1:0]            y_coordinate_1,
  output logic [COORD_W-1:0]            x_coordinate_2,
  output logic [COORD_W-1:0]            y_coordinate_2,
  output logic [1:0]                    edge_index,
  input  logic                          line_done,
  output logic                          tri_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] x3;
    logic [COORD_W-1:0] y3;
  } rec_t;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  rec_t               work_q, work_d;
  rec_t               in_rec, head;
  logic [CW-1:0]      count;
  logic               push, pop;
  logic               rdy_en_q;
  logic               done_q, done_d;
  logic [COORD_W-1:0] ax, ay, bx, by;
  logic [COORD_W-1:0] hx1_q, hy1_q, hx2_q, hy2_q;
  logic               skip_edge;
  logic               tri_last;

  // tri_ready stays low through reset and rises on the first clock after release.
  assign tri_ready = rdy_en_q && (count < CW'(FIFO_DEPTH));
  assign push      = tri_valid && tri_ready;
  assign in_rec    = {x_vertice_1, y_vertice_1, x_vertice_2, y_vertice_2,
                      x_vertice_3, y_vertice_3};

  tri_fifo #(
    .T     (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (in_rec),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  // Select the current edge's endpoints from the working triangle.
  always_comb begin
    ax = work_q.x1;
    ay = work_q.y1;
    bx = work_q.x2;
    by = work_q.y2;
    case (idx_q)
      EDGE_V1V2: begin ax = work_q.x1; ay = work_q.y1; bx = work_q.x2; by = work_q.y2; end
      EDGE_V1V3: begin ax = work_q.x1; ay = work_q.y1; bx = work_q.x3; by = work_q.y3; end
      default:   begin ax = work_q.x2; ay = work_q.y2; bx = work_q.x3; by = work_q.y3; end
    endcase
  end

  assign skip_edge  = SKIP_DEGENERATE && (ax == bx) && (ay == by);
  assign edge_valid = (state_q == ISSUE) && !skip_edge;
  assign tri_last   = (idx_q == EDGE_V2V3) &&
                      (((state_q == ISSUE) && skip_edge) ||
                       ((state_q == WAIT_DONE) && line_done));

  // Next-state logic. Triangle completion and the idle pop share one pop path
  // so a queued triangle starts back-to-back without passing through IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    if (tri_last) begin
      done_d  = 1'b1;
      state_d = IDLE;
      idx_d   = EDGE_V1V2;
    end else begin
      case (state_q)
        ISSUE: begin
          if (skip_edge)       idx_d   = idx_q + 2'd1;
          else if (edge_ready) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (line_done) begin
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end
        default: state_d = state_q;
      endcase
    end
    if (((state_q == IDLE) || tri_last) && (count != '0)) begin
      pop     = 1'b1;
      work_d  = head;
      idx_d   = EDGE_V1V2;
      state_d = ISSUE;
    end
  end

  // FSM, working triangle and completion pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      work_q   <= '0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      work_q   <= work_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Remember the last issued endpoints so the outputs hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hx1_q <= '0;
      hy1_q <= '0;
      hx2_q <= '0;
      hy2_q <= '0;
    end else if (edge_valid) begin
      hx1_q <= ax;
      hy1_q <= ay;
      hx2_q <= bx;
      hy2_q <= by;
    end
  end

  assign x_coordinate_1 = edge_valid ? ax : hx1_q;
  assign y_coordinate_1 = edge_valid ? ay : hy1_q;
  assign x_coordinate_2 = edge_valid ? bx : hx2_q;
  assign y_coordinate_2 = edge_valid ? by : hy2_q;
  assign edge_index     = idx_q;
  assign tri_done       = done_q;
  assign fifo_count     = count;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_triangle_edge_scheduler.sv
// Scoreboard bench for triangle_edge_scheduler with a simple line-engine model.
module tb_triangle_edge_scheduler;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tri_valid = 1'b0;
  logic         edge_ready = 1'b0;
  logic         line_done = 1'b0;
  logic [W-1:0] xv1 = '0, xv2 = '0, xv3 = '0, yv1 = '0, yv2 = '0, yv3 = '0;
  logic         tri_ready, edge_valid, tri_done, busy;
  logic [W-1:0] xc1, yc1, xc2, yc2;
  logic [1:0]   edge_index;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  triangle_edge_scheduler #(
    .COORD_W         (W),
    .FIFO_DEPTH      (DEPTH),
    .SKIP_DEGENERATE (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tri_valid      (tri_valid),
    .tri_ready      (tri_ready),
    .x_vertice_1    (xv1),
    .x_vertice_2    (xv2),
    .x_vertice_3    (xv3),
    .y_vertice_1    (yv1),
    .y_vertice_2    (yv2),
    .y_vertice_3    (yv3),
    .edge_valid     (edge_valid),
    .edge_ready     (edge_ready),
    .x_coordinate_1 (xc1),
    .y_coordinate_1 (yc1),
    .x_coordinate_2 (xc2),
    .y_coordinate_2 (yc2),
    .edge_index     (edge_index),
    .line_done      (line_done),
    .tri_done       (tri_done),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  typedef struct {
    logic [W-1:0] x1, y1, x2, y2;
    logic [1:0]   idx;
  } edge_t;

  edge_t exp_edges[$];
  int    exp_done[$];
  int    n_cmp = 0, n_err = 0;
  int    tri_id = 0;
  bit    ready_en = 1'b1;
  int    done_delay = 3;
  int    hang_idx = -1;
  int    stall_idx = -1;
  int    stall_left = 0;
  int    idle_cnt = 0;
  int    done_seen = 0;
  int    cnt = 0;
  logic  busy_at_done = 1'b1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_edge(input logic [W-1:0] ax, input logic [W-1:0] ay,
                          input logic [W-1:0] bx, input logic [W-1:0] by,
                          input logic [1:0] idx);
    edge_t e;
    if (!((ax == bx) && (ay == by))) begin
      e.x1 = ax; e.y1 = ay; e.x2 = bx; e.y2 = by; e.idx = idx;
      exp_edges.push_back(e);
    end
  endtask

  task automatic sb_push();
    add_edge(xv1, yv1, xv2, yv2, 2'd0);
    add_edge(xv1, yv1, xv3, yv3, 2'd1);
    add_edge(xv2, yv2, xv3, yv3, 2'd2);
    exp_done.push_back(tri_id);
    tri_id++;
  endtask

  task automatic drive_tri(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3);
    xv1 = W'(x1); yv1 = W'(y1);
    xv2 = W'(x2); yv2 = W'(y2);
    xv3 = W'(x3); yv3 = W'(y3);
    tri_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int unsigned t = 0;
    while (!tri_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk_eq("push_accept", tri_ready, 1'b1);
    if (tri_ready) sb_push();
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic push_tri(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3);
    drive_tri(x1, y1, x2, y2, x3, y3);
    wait_accept();
  endtask

  task automatic wait_drain(input int unsigned bound);
    int unsigned t = 0;
    while ((exp_edges.size() != 0 || exp_done.size() != 0 || busy || cnt != 0) && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk_eq("drain_edges", exp_edges.size(), 0);
    chk_eq("drain_tri_done", exp_done.size(), 0);
  endtask

  // Line-engine model and output monitor, evaluated away from the active edge.
  initial begin : engine
    edge_t e;
    forever begin
      @(negedge clk);
      line_done = 1'b0;
      if (!reset) begin
        cnt = 0;
        edge_ready = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) line_done = 1'b1;
        end
        if (edge_valid && stall_left > 0 && int'(edge_index) == stall_idx) begin
          edge_ready = 1'b0;
          stall_left--;
          if (exp_edges.size() > 0) begin
            chk_eq("stall_x1", xc1, exp_edges[0].x1);
            chk_eq("stall_y1", yc1, exp_edges[0].y1);
            chk_eq("stall_x2", xc2, exp_edges[0].x2);
            chk_eq("stall_y2", yc2, exp_edges[0].y2);
            chk_eq("stall_idx", edge_index, exp_edges[0].idx);
          end
          if (stall_left % 2 == 0) line_done = 1'b1;
        end else begin
          edge_ready = ready_en;
        end
        if (edge_valid && edge_ready) begin
          if (exp_edges.size() == 0) begin
            chk_eq("unexpected_edge", exp_edges.size(), 1);
          end else begin
            e = exp_edges.pop_front();
            chk_eq("edge_x1", xc1, e.x1);
            chk_eq("edge_y1", yc1, e.y1);
            chk_eq("edge_x2", xc2, e.x2);
            chk_eq("edge_y2", yc2, e.y2);
            chk_eq("edge_index", edge_index, e.idx);
          end
          cnt = (int'(edge_index) == hang_idx) ? 0 : done_delay;
        end
      end
      if (tri_done) begin
        if (exp_done.size() == 0) chk_eq("unexpected_tri_done", exp_done.size(), 1);
        else void'(exp_done.pop_front());
        done_seen++;
        busy_at_done = busy;
      end
      if (!busy && exp_done.size() > 0) idle_cnt++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    repeat (2) @(negedge clk);
    chk_eq("rst_tri_ready", tri_ready, 1'b0);
    chk_eq("rst_edge_valid", edge_valid, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_fifo_count", fifo_count, 0);
    chk_eq("rst_tri_done", tri_done, 1'b0);
    chk_eq("rst_edge_index", edge_index, 0);
    chk_eq("rst_x1", xc1, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("tri_ready_after_release", tri_ready, 1'b1);

    // Single triangle, 2-cycle issue latency.
    d0 = done_seen;
    push_tri(10, 20, 30, 40, 50, 5);
    chk_eq("latency_cycle1_valid", edge_valid, 1'b0);
    @(negedge clk);
    chk_eq("latency_cycle2_valid", edge_valid, 1'b1);
    wait_drain(200);
    chk_eq("t1_tri_done_count", done_seen - d0, 1);
    chk_eq("t1_busy_at_done", busy_at_done, 1'b0);
    chk_eq("t1_hold_x2", xc2, 50);

    // Backpressure on edge 1 with stray line_done pulses.
    stall_idx = 1;
    stall_left = 5;
    push_tri(10, 20, 30, 40, 50, 5);
    wait_drain(200);
    chk_eq("t2_stall_consumed", stall_left, 0);
    stall_idx = -1;

    // Queue full while the engine is stalled.
    ready_en = 1'b0;
    d0 = done_seen;
    push_tri(1, 2, 3, 4, 5, 6);
    @(negedge clk);
    push_tri(11, 12, 13, 14, 15, 16);
    push_tri(21, 22, 23, 24, 25, 26);
    push_tri(31, 32, 33, 34, 35, 36);
    push_tri(41, 42, 43, 44, 45, 46);
    chk_eq("full_count", fifo_count, 4);
    chk_eq("full_tri_ready", tri_ready, 1'b0);
    drive_tri(51, 52, 53, 54, 55, 56);
    @(negedge clk);
    chk_eq("fifth_held", tri_ready, 1'b0);
    idle_cnt = 0;
    ready_en = 1'b1;
    wait_accept();
    wait_drain(600);
    chk_eq("full_tri_done_count", done_seen - d0, 6);
    chk_eq("full_no_idle_gap", idle_cnt, 0);

    // Degenerate edges.
    d0 = done_seen;
    push_tri(7, 7, 7, 7, 9, 1);
    push_tri(3, 3, 3, 3, 3, 3);
    wait_drain(300);
    chk_eq("degen_tri_done_count", done_seen - d0, 2);

    // Reset during WAIT_DONE of edge 1 with two triangles queued.
    hang_idx = 1;
    push_tri(100, 200, 300, 400, 500, 600);
    push_tri(110, 210, 310, 410, 510, 610);
    push_tri(120, 220, 320, 420, 520, 620);
    repeat (15) @(negedge clk);
    chk_eq("pre_rst_busy", busy, 1'b1);
    chk_eq("pre_rst_valid", edge_valid, 1'b0);
    chk_eq("pre_rst_index", edge_index, 1);
    chk_eq("pre_rst_count", fifo_count, 2);
    d0 = done_seen;
    reset = 1'b0;
    exp_edges.delete();
    exp_done.delete();
    hang_idx = -1;
    #1;
    chk_eq("mid_rst_tri_ready", tri_ready, 1'b0);
    chk_eq("mid_rst_valid", edge_valid, 1'b0);
    chk_eq("mid_rst_busy", busy, 1'b0);
    chk_eq("mid_rst_count", fifo_count, 0);
    chk_eq("mid_rst_index", edge_index, 0);
    chk_eq("mid_rst_x1", xc1, 0);
    chk_eq("mid_rst_y2", yc2, 0);
    repeat (3) @(negedge clk);
    chk_eq("held_rst_tri_ready", tri_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_tri_ready", tri_ready, 1'b1);
    chk_eq("no_tri_done_in_reset", done_seen - d0, 0);
    push_tri(1, 1, 4, 1, 1, 5);
    wait_drain(300);
    chk_eq("post_rst_tri_done_count", done_seen - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
